// File: rtl/gs232c_bhr_pkg.sv
// Shared constants, history type and the shift-in helper for the gs232c branch-history manager.
package gs232c_bhr_pkg;
    localparam int HW_DEF    = 25;
    localparam int TW_DEF    = 21;
    localparam int DEPTH_DEF = 8;
    // Working width of shift_in; callers zero-extend into it and truncate the result.
    localparam int SHW       = 64;

    typedef logic [HW_DEF-1:0] bhr_hist_t;

    function automatic logic [SHW-1:0] shift_in(logic [SHW-1:0] hist, logic [2:0] n, logic b_in);
        return (hist << n) | {{(SHW-1){1'b0}}, b_in};
    endfunction
endpackage

// File: rtl/gs232c_bhr_if.sv
// Fetch/resolve/commit bus between the branch-history manager and its neighbours.
interface gs232c_bhr_if #(
    parameter int HW = gs232c_bhr_pkg::HW_DEF,
    parameter int TW = gs232c_bhr_pkg::TW_DEF,
    parameter int QW = 3
);
    logic          fe_go;
    logic [2:0]    fe_nbr;
    logic          fe_taken;
    logic [31:0]   fe_pc;
    logic          fe_ready;
    logic [QW-1:0] fe_qid;
    logic          br_brop;
    logic          br_cancel;
    logic [QW-1:0] br_qid;
    logic [2:0]    br_nbr;
    logic          br_taken;
    logic          cm_go;
    logic [TW-1:0] bhr_bt;
    logic [HW-1:0] bhr_br;
    logic          q_empty;

    modport master (
        output fe_go, fe_nbr, fe_taken, fe_pc, br_brop, br_cancel, br_qid, br_nbr, br_taken, cm_go,
        input  fe_ready, fe_qid, bhr_bt, bhr_br, q_empty
    );
    modport slave (
        input  fe_go, fe_nbr, fe_taken, fe_pc, br_brop, br_cancel, br_qid, br_nbr, br_taken, cm_go,
        output fe_ready, fe_qid, bhr_bt, bhr_br, q_empty
    );
endinterface

// File: rtl/gs232c_bhr_ckq.sv
// Checkpoint ring: per-block history snapshots plus head/tail/count; count separates full from empty.
module gs232c_bhr_ckq #(
    parameter int HW    = gs232c_bhr_pkg::HW_DEF,
    parameter int DEPTH = gs232c_bhr_pkg::DEPTH_DEF,
    parameter int QW    = $clog2(DEPTH)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          i_push,
    input  logic [HW-1:0] i_push_hist,
    input  logic          i_push_path,
    input  logic          i_pop,
    input  logic          i_rewind,
    input  logic [QW-1:0] i_rewind_qid,
    input  logic [QW-1:0] i_rd_qid,
    output logic [HW-1:0] o_rd_hist,
    output logic          o_rd_path,
    output logic [QW-1:0] o_tail,
    output logic          o_ready,
    output logic          o_empty
);
    logic [HW-1:0] r_hist [DEPTH];
    logic [DEPTH-1:0] r_path;
    logic [QW-1:0] r_head, r_tail;
    logic [QW:0]   r_count;

    logic          w_pop;
    logic [QW-1:0] w_qid_inc, w_keep;
    logic [QW:0]   w_rw_cnt;

    assign w_pop     = i_pop & (r_count != '0);
    assign w_qid_inc = i_rewind_qid + QW'(1);
    assign w_keep    = w_qid_inc - r_head;
    // A live qid only wraps back to head when every entry is kept, i.e. the ring was full.
    assign w_rw_cnt  = (w_keep == '0) ? (QW+1)'(DEPTH) : {1'b0, w_keep};

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            r_path  <= '0;
            for (int i = 0; i < DEPTH; i++) r_hist[i] <= '0;
        end else begin
            if (i_push) begin
                r_hist[r_tail] <= i_push_hist;
                r_path[r_tail] <= i_push_path;
            end
            if (i_rewind) begin
                r_tail  <= w_qid_inc;
                r_count <= w_rw_cnt - (QW+1)'(w_pop);
            end else begin
                r_tail  <= r_tail + QW'(i_push);
                r_count <= r_count + (QW+1)'(i_push) - (QW+1)'(w_pop);
            end
            r_head <= r_head + QW'(w_pop);
        end
    end

    assign o_rd_hist = r_hist[i_rd_qid];
    assign o_rd_path = r_path[i_rd_qid];
    assign o_tail    = r_tail;
    assign o_ready   = (r_count != (QW+1)'(DEPTH));
    assign o_empty   = (r_count == '0);
endmodule

// File: rtl/gs232c_bhr.sv
// Global branch-history manager: speculative history, checkpoint queue and mispredict restore.
// Optional GS232C_BHR_PATH_EN: taken-branch insert bit becomes ~fe_pc[2] and is kept per checkpoint.
module gs232c_bhr
    import gs232c_bhr_pkg::*;
#(
    parameter int HW    = HW_DEF,
    parameter int TW    = TW_DEF,
    parameter int DEPTH = DEPTH_DEF,
    parameter int QW    = $clog2(DEPTH)
) (
    input  logic clock,
    input  logic reset,
    gs232c_bhr_if.slave bus
);
    logic [HW-1:0] r_spec;
    logic [HW-1:0] w_spec_nxt, w_rd_hist, w_bhr_br;
    logic          w_rd_path, w_path, w_berr, w_push, w_push_bit, w_ready, w_empty;
    logic [QW-1:0] w_tail;

`ifdef GS232C_BHR_PATH_EN
    assign w_path = ~bus.fe_pc[2];
`else
    assign w_path = 1'b1;
`endif

    assign w_berr     = bus.br_brop & bus.br_cancel;
    assign w_push     = bus.fe_go & w_ready & ~w_berr;
    assign w_push_bit = bus.fe_taken & (bus.fe_nbr != 3'd0) & w_path;
    // Same-cycle resolved history: the BHT samples it alongside br_brop.
    assign w_bhr_br   = HW'(shift_in(SHW'(w_rd_hist), bus.br_nbr, bus.br_taken & w_rd_path));

    always_comb begin
        w_spec_nxt = r_spec;
        if (w_berr)
            w_spec_nxt = w_bhr_br;
        else if (w_push)
            w_spec_nxt = HW'(shift_in(SHW'(r_spec), bus.fe_nbr, w_push_bit));
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) r_spec <= '0;
        else        r_spec <= w_spec_nxt;
    end

    gs232c_bhr_ckq #(.HW(HW), .DEPTH(DEPTH), .QW(QW)) u_ckq (
        .clock        (clock),
        .reset        (reset),
        .i_push       (w_push),
        .i_push_hist  (r_spec),
        .i_push_path  (w_path),
        .i_pop        (bus.cm_go),
        .i_rewind     (w_berr),
        .i_rewind_qid (bus.br_qid),
        .i_rd_qid     (bus.br_qid),
        .o_rd_hist    (w_rd_hist),
        .o_rd_path    (w_rd_path),
        .o_tail       (w_tail),
        .o_ready      (w_ready),
        .o_empty      (w_empty)
    );

    assign bus.bhr_bt   = r_spec[TW-1:0];
    assign bus.bhr_br   = w_bhr_br;
    assign bus.fe_ready = w_ready;
    assign bus.fe_qid   = w_tail;
    assign bus.q_empty  = w_empty;
endmodule

// File: tb/tb_gs232c_bhr.sv
// Bench for gs232c_bhr: directed tables, multi-cycle corner sequences and random traffic vs a queue model.
module tb_gs232c_bhr;
    import gs232c_bhr_pkg::*;
    localparam int HW = 25, TW = 21, DEPTH = 8, QW = 3;
    localparam longint HMASK = (64'd1 << HW) - 1;
    localparam longint TMASK = (64'd1 << TW) - 1;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    gs232c_bhr_if #(.HW(HW), .TW(TW), .QW(QW)) bus ();
    gs232c_bhr #(.HW(HW), .TW(TW), .DEPTH(DEPTH), .QW(QW)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        bit go; int nbr; bit tk; bit cm;
        bit brop; bit cancel; int qid; int bnbr; bit btk;
    } in_t;
    typedef struct { int qid; longint hist; } ent_t;
    typedef struct { int nbr; bit tk; longint exp_bt; int exp_qid; } vec_t;

    ent_t   mq[$];
    longint m_spec;
    int     m_head;
    int     n_chk = 0, n_fail = 0;
    longint last_qid, last_br;

    task automatic chk(string nm, longint act, longint exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    function automatic in_t mk(bit go, int nbr, bit tk, bit cm, bit brop = 0, bit cancel = 0,
                               int qid = 0, int bnbr = 1, bit btk = 0);
        in_t s;
        s.go = go; s.nbr = nbr; s.tk = tk; s.cm = cm;
        s.brop = brop; s.cancel = cancel; s.qid = qid; s.bnbr = bnbr; s.btk = btk;
        return s;
    endfunction

    task automatic clr_in();
        bus.fe_go = 0; bus.fe_nbr = 0; bus.fe_taken = 0; bus.fe_pc = 0;
        bus.br_brop = 0; bus.br_cancel = 0; bus.br_qid = 0; bus.br_nbr = 0;
        bus.br_taken = 0; bus.cm_go = 0;
    endtask

    function automatic void model_reset();
        mq.delete();
        m_spec = 0;
        m_head = 0;
    endfunction

    // One clock: drive, check same-cycle outputs, advance model, check registered outputs.
    task automatic cyc(in_t s);
        int k;
        longint exp_br;
        bit push, pop;
        @(negedge clock);
        bus.fe_go = s.go; bus.fe_nbr = 3'(s.nbr); bus.fe_taken = s.tk; bus.fe_pc = $urandom;
        bus.br_brop = s.brop; bus.br_cancel = s.cancel; bus.br_qid = QW'(s.qid);
        bus.br_nbr = 3'(s.bnbr); bus.br_taken = s.btk; bus.cm_go = s.cm;
        #1;
        last_qid = bus.fe_qid;
        last_br  = bus.bhr_br;
        chk("fe_qid", bus.fe_qid, (m_head + mq.size()) % DEPTH);
        chk("fe_ready", bus.fe_ready, mq.size() < DEPTH);
        chk("q_empty", bus.q_empty, mq.size() == 0);
        k = -1;
        exp_br = 0;
        if (s.brop) begin
            foreach (mq[i]) if (mq[i].qid == s.qid) k = i;
            chk("br_qid_live", k >= 0, 1);
            if (k >= 0) begin
                exp_br = ((mq[k].hist << s.bnbr) | longint'(s.btk)) & HMASK;
                chk("bhr_br", bus.bhr_br, exp_br);
            end
        end
        if (s.brop && s.cancel && k >= 0) begin
            m_spec = exp_br;
            while (mq.size() > k + 1) void'(mq.pop_back());
            if (s.cm) begin
                void'(mq.pop_front());
                m_head = (m_head + 1) % DEPTH;
            end
        end else if (!(s.brop && s.cancel)) begin
            push = s.go && mq.size() < DEPTH;
            pop  = s.cm && mq.size() > 0;
            if (push) begin
                mq.push_back('{(m_head + mq.size()) % DEPTH, m_spec});
                if (s.nbr != 0) m_spec = ((m_spec << s.nbr) | longint'(s.tk)) & HMASK;
            end
            if (pop) begin
                void'(mq.pop_front());
                m_head = (m_head + 1) % DEPTH;
            end
        end
        @(posedge clock);
        #1;
        chk("bhr_bt", bus.bhr_bt, m_spec & TMASK);
        chk("count", dut.u_ckq.r_count, mq.size());
        chk("head", dut.u_ckq.r_head, m_head);
        clr_in();
    endtask

    // Reset asserted between edges: outputs must clear without waiting for a clock.
    task automatic do_reset();
        #3 reset = 0;
        #1;
        chk("rst_bt", bus.bhr_bt, 0);
        chk("rst_ready", bus.fe_ready, 1);
        chk("rst_empty", bus.q_empty, 1);
        chk("rst_qid", bus.fe_qid, 0);
        model_reset();
        @(negedge clock);
        reset = 1;
    endtask

    vec_t tbl[4];

    initial begin
        clr_in();
        model_reset();
        #12;
        chk("init_bt", bus.bhr_bt, 0);
        chk("init_ready", bus.fe_ready, 1);
        chk("init_empty", bus.q_empty, 1);
        @(negedge clock);
        reset = 1;

        // Push table; nbr=0 with taken must leave the history alone.
        tbl[0] = '{2, 1, 64'h1, 0};
        tbl[1] = '{1, 1, 64'h3, 1};
        tbl[2] = '{0, 1, 64'h3, 2};
        tbl[3] = '{1, 0, 64'h6, 3};
        foreach (tbl[i]) begin
            cyc(mk(1, tbl[i].nbr, tbl[i].tk, 0));
            chk("tbl_qid", last_qid, tbl[i].exp_qid);
            chk("tbl_bt", bus.bhr_bt, tbl[i].exp_bt);
        end
        // Mispredict on block 1 (checkpoint 0x1), not taken: restore 0x2, keep blocks 0..1.
        cyc(mk(0, 0, 0, 0, 1, 1, 1, 1, 0));
        chk("mp_br", last_br, 64'h2);
        chk("mp_bt", bus.bhr_bt, 64'h2);
        chk("mp_tail", bus.fe_qid, 2);
        chk("mp_cnt", dut.u_ckq.r_count, 2);

        // Fill, overflow attempt, then pop+push around the full boundary.
        do_reset();
        for (int i = 0; i < DEPTH; i++) cyc(mk(1, 1, 1, 0));
        chk("full_ready", bus.fe_ready, 0);
        cyc(mk(1, 1, 1, 0));
        chk("ovf_cnt", dut.u_ckq.r_count, 8);
        chk("ovf_bt", bus.bhr_bt, 64'hFF);
        cyc(mk(1, 1, 1, 1));
        chk("fullpop_cnt", dut.u_ckq.r_count, 7);
        chk("fullpop_tail", bus.fe_qid, 0);
        cyc(mk(1, 1, 1, 1));
        chk("wrap_tail", bus.fe_qid, 1);
        chk("wrap_head", dut.u_ckq.r_head, 2);
        // Mispredict with push and pop: ckpt[4]=0xF -> 0x3D, tail 5, head 3, count 2.
        cyc(mk(1, 2, 1, 1, 1, 1, 4, 2, 1));
        chk("mpx_br", last_br, 64'h3D);
        chk("mpx_bt", bus.bhr_bt, 64'h3D);
        chk("mpx_tail", bus.fe_qid, 5);
        chk("mpx_cnt", dut.u_ckq.r_count, 2);

        // Long run of taken branches saturates the history at HW bits.
        do_reset();
        for (int i = 0; i < 30; i++) cyc(mk(1, 1, 1, 1));
        chk("sat_bt", bus.bhr_bt, 64'h1FFFFF);
        chk("sat_spec", dut.r_spec, 64'h1FFFFFF);

        // Reset mid-stream with a non-empty queue.
        cyc(mk(1, 3, 1, 0));
        cyc(mk(1, 4, 0, 0));
        do_reset();

        // Random traffic; resolves only target live blocks.
        for (int n = 0; n < 400; n++) begin
            in_t s;
            s = mk($urandom_range(0, 3) != 0, $urandom_range(0, 4), $urandom_range(0, 1),
                   $urandom_range(0, 2) == 0);
            if (mq.size() > 0 && $urandom_range(0, 3) == 0) begin
                s.brop   = 1;
                s.cancel = $urandom_range(0, 1);
                s.qid    = mq[$urandom_range(0, mq.size() - 1)].qid;
                s.bnbr   = $urandom_range(1, 4);
                s.btk    = $urandom_range(0, 1);
            end
            cyc(s);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
